// File: rtl/fifo_byte_serializer.sv
// Pops words from a FIFO with one-cycle read latency and streams each word out MSB byte first
// on a valid/ready port, counting fully transmitted words.
module fifo_byte_serializer #(
  parameter int unsigned word_length = 32,
  parameter int unsigned byte_width  = 8,
  parameter int unsigned count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [word_length-1:0] fifo_data,
  output logic                   pop,
  output logic [byte_width-1:0]  byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic [count_width-1:0] word_count
);

  localparam int unsigned NumBytes = word_length / byte_width;
  localparam int unsigned IdxWidth = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBytes - 1);

  if ((byte_width == 0) || (word_length % byte_width != 0)) begin : gen_width_check
    $error("word_length must be a non-zero multiple of byte_width");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  state_e                 state_q, state_d;
  logic [word_length-1:0] shift_q, shift_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [count_width-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   handshake;

  // valid_q is only ever set in StSend, so it also qualifies the handshake by state.
  assign handshake = valid_q && byte_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    count_d = count_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        shift_d = fifo_data;
        idx_d   = LastIdx;
        state_d = StSend;
      end
      StSend: begin
        if (handshake) begin
          if (idx_q != '0) begin
            shift_d = shift_q << byte_width;
            idx_d   = idx_q - IdxWidth'(1);
          end else begin
            count_d = count_q + count_width'(1);
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = StLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop seen by the FIFO during reset would lose a word the serializer never loads.
    if (!rst) begin
      pop = 1'b0;
    end
  end

  assign valid_d = (state_d == StSend);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign byte_out   = shift_q[word_length-1 -: byte_width];
  assign byte_valid = valid_q;
  assign busy       = (state_q != StIdle);
  assign word_count = count_q;

endmodule
